display_sequencer: RTL and testbench
====================================

DISPLAY_SEQUENCER -- requirements
Module: display_sequencer

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6, meaning number of digits per frame (1..8).
REQ-002 SHALL have parameter WIDTH, default 16, meaning shift-word width: {segments[15:8], digit_select[7:0]}.
REQ-003 SHALL have port i_clk  input  1  system clock; the only clock.
REQ-004 SHALL have port i_reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port i_refresh_stb  input  1  one-cycle request to send one frame.
REQ-006 SHALL have port i_bcd_time  input  24  {h_tens,h_ones,m_tens,m_ones,s_tens,s_ones}, 4 bits each.
REQ-007 SHALL have port i_colon  input  1  lights dp on digits 1 and 3.
REQ-008 SHALL have port i_blank  input  1  forces all segment bits to 0.
REQ-009 SHALL have port i_busy  input  1  busy flag from the downstream shift_register.
REQ-010 SHALL have port o_parallel_data  output  WIDTH  word presented to shift_register.
REQ-011 SHALL have port o_start_stb  output  1  one-cycle start pulse to shift_register.
REQ-012 SHALL have port o_busy  output  1  high while a frame is in progress.
REQ-013 SHALL have port o_frame_done  output  1  one-cycle pulse after the last digit completes.

Function
REQ-014 SHALL use FSM states IDLE, LOAD, START, WAIT_ACK, WAIT_DONE, NEXT.
REQ-015 IDLE: on i_refresh_stb or pending flag, SHALL snapshot i_bcd_time, i_colon and i_blank, set digit index to 0, clear pending, and go to LOAD.
REQ-016 LOAD SHALL register o_parallel_data = {seg(idx), 8'b1<<idx}, then go to START; o_parallel_data SHALL hold stable until the next LOAD.
REQ-017 START SHALL assert o_start_stb for exactly one cycle, then go to WAIT_ACK.
REQ-018 WAIT_ACK SHALL stay until i_busy=1, then go to WAIT_DONE; WAIT_DONE SHALL stay until i_busy=0, then go to NEXT.
REQ-019 NEXT: if idx=NUM_DIGITS-1, SHALL pulse o_frame_done for one cycle and go to IDLE; otherwise SHALL increment idx and go to LOAD.
REQ-020 Digit idx 0 SHALL be h_tens (leftmost) and SHALL be sent first; each following idx SHALL take the next nibble toward s_ones.
REQ-021 Segment byte SHALL be {dp,g,f,e,d,c,b,a}; codes 0-9 SHALL be 3F,06,5B,4F,66,6D,7D,07,7F,6F hex.
REQ-022 A nibble greater than 9 SHALL encode as a dash, 40 hex.
REQ-023 A zero h_tens digit SHALL be blanked (segments 00), except for dp.
REQ-024 Snapshot i_colon=1 SHALL set dp on idx 1 and 3; snapshot i_blank=1 SHALL force the segment byte to 00, and digit select SHALL still cycle.
REQ-025 o_busy SHALL be 0 in IDLE and 1 in every other state.
REQ-026 i_refresh_stb while o_busy=1 SHALL set a single pending flag; further strobes SHALL be dropped.
REQ-027 A pending frame SHALL start in the cycle after o_frame_done.
REQ-028 Changes to inputs mid-frame SHALL NOT affect the frame in progress.

Reset
REQ-029 Asserting i_reset_n=0 SHALL immediately force state IDLE, idx 0, pending 0, o_parallel_data 0, o_start_stb 0, o_busy 0 and o_frame_done 0, including mid-frame.
REQ-030 After reset release, the first frame SHALL start only on a new i_refresh_stb.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, the segment code constants (SEG_0..SEG_9, SEG_DASH, SEG_DP) and the field offsets of WIDTH.
REQ-032 Decoding SHALL be done in one combinational sub-module, bcd_to_7seg (4-bit in, 7-bit out, dash on invalid input).

Verification
REQ-033 Reset, then i_bcd_time=0x123456, i_colon=0, one strobe, with a shift_register model SHALL produce words 0601, 5B02, 4F04, 6608, 6D10, 7D20 and one o_frame_done.
REQ-034 i_bcd_time=0x094500, i_colon=1 SHALL produce first word 0001 and second word EF02, and idx 3 SHALL carry dp set.
REQ-035 i_blank=1 SHALL produce words 0001, 0002, 0004, 0008, 0010, 0020.
REQ-036 Three strobes during a frame SHALL produce exactly one extra frame, starting the cycle after o_frame_done.
REQ-037 With i_busy held low for 50 cycles after o_start_stb, the sequencer SHALL remain in WAIT_ACK with no further o_start_stb.
REQ-038 Reset asserted in WAIT_DONE of idx 2 SHALL zero all outputs at once, and no further o_start_stb SHALL occur without a new strobe.
REQ-039 h_tens=0xA SHALL produce segment byte 40 for idx 0.

Source files
------------

// File: rtl/display_sequencer_pkg.sv
// rtl/display_sequencer_pkg.sv - shared FSM states, segment codes and shift-word layout
package display_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_ACK,
    WAIT_DONE,
    NEXT
  } state_t;

  // Segment order {g,f,e,d,c,b,a}; dp sits above them in the segment byte
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [7:0] SEG_DP   = 8'h80;

  localparam int SEL_LSB = 0;
  localparam int SEL_W   = 8;
  localparam int SEG_LSB = 8;
  localparam int SEG_W   = 8;
  localparam int IDX_W   = 3;

endpackage

// File: rtl/display_sequencer_bcd_to_7seg.sv
// rtl/display_sequencer_bcd_to_7seg.sv - combinational BCD nibble to 7-segment decoder
module bcd_to_7seg
  import display_sequencer_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    unique case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_sequencer.sv
// rtl/display_sequencer.sv - sends one time frame, digit by digit, to a downstream shift register
module display_sequencer
  import display_sequencer_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int WIDTH      = 16
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_refresh_stb,
  input  logic [23:0]      i_bcd_time,
  input  logic             i_colon,
  input  logic             i_blank,
  input  logic             i_busy,
  output logic [WIDTH-1:0] o_parallel_data,
  output logic             o_start_stb,
  output logic             o_busy,
  output logic             o_frame_done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  state_t           state, next_state;
  logic [IDX_W-1:0] idx;
  logic             pending;
  logic [23:0]      bcd_snap;
  logic             colon_snap;
  logic             blank_snap;
  logic             start_frame, load_word, advance;

  logic [31:0]      digits;
  logic [3:0]       nibble;
  logic [6:0]       seg7;
  logic [7:0]       seg_byte;
  logic [WIDTH-1:0] word;

  // Positions past the six time digits read as 0xF and therefore show a dash
  assign digits = {bcd_snap, 8'hFF};
  assign nibble = digits[5'd31 - {idx, 2'b00} -: 4];

  bcd_to_7seg u_dec (
    .bcd (nibble),
    .seg (seg7)
  );

  always_comb begin
    seg_byte = {1'b0, seg7};
    if (idx == '0 && nibble == 4'd0)
      seg_byte = 8'h00;
    if (colon_snap && (idx == IDX_W'(1) || idx == IDX_W'(3)))
      seg_byte = seg_byte | SEG_DP;
    if (blank_snap)
      seg_byte = 8'h00;
    word = '0;
    word[SEG_LSB +: SEG_W] = seg_byte;
    word[SEL_LSB +: SEL_W] = 8'd1 << idx;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state   = state;
    start_frame  = 1'b0;
    load_word    = 1'b0;
    advance      = 1'b0;
    o_start_stb  = 1'b0;
    o_frame_done = 1'b0;
    o_busy       = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (i_refresh_stb || pending) begin
          start_frame = 1'b1;
          next_state  = LOAD;
        end
      end
      LOAD: begin
        load_word  = 1'b1;
        next_state = START;
      end
      START: begin
        o_start_stb = 1'b1;
        next_state  = WAIT_ACK;
      end
      WAIT_ACK:  if (i_busy)  next_state = WAIT_DONE;
      WAIT_DONE: if (!i_busy) next_state = NEXT;
      NEXT: begin
        if (idx == LAST_IDX) begin
          o_frame_done = 1'b1;
          next_state   = IDLE;
        end else begin
          advance    = 1'b1;
          next_state = LOAD;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      idx             <= '0;
      pending         <= 1'b0;
      bcd_snap        <= '0;
      colon_snap      <= 1'b0;
      blank_snap      <= 1'b0;
      o_parallel_data <= '0;
    end else begin
      if (start_frame) begin
        bcd_snap   <= i_bcd_time;
        colon_snap <= i_colon;
        blank_snap <= i_blank;
        idx        <= '0;
        pending    <= 1'b0;
      end else if (i_refresh_stb && state != IDLE) begin
        pending <= 1'b1;
      end
      if (advance)
        idx <= idx + IDX_W'(1);
      if (load_word)
        o_parallel_data <= word;
    end
  end

endmodule

// File: tb/tb_display_sequencer.sv
// tb/tb_display_sequencer.sv - randomized self-checking bench with a shift-register responder
module tb_display_sequencer;

  localparam int ND = 6;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_refresh_stb = 1'b0;
  logic [23:0] i_bcd_time = '0;
  logic        i_colon = 1'b0;
  logic        i_blank = 1'b0;
  logic        i_busy = 1'b0;
  logic [15:0] o_parallel_data;
  logic        o_start_stb;
  logic        o_busy;
  logic        o_frame_done;

  int n_pass = 0;
  int n_total = 0;

  display_sequencer #(.NUM_DIGITS(ND), .WIDTH(16)) dut (
    .i_clk           (i_clk),
    .i_reset_n       (i_reset_n),
    .i_refresh_stb   (i_refresh_stb),
    .i_bcd_time      (i_bcd_time),
    .i_colon         (i_colon),
    .i_blank         (i_blank),
    .i_busy          (i_busy),
    .o_parallel_data (o_parallel_data),
    .o_start_stb     (o_start_stb),
    .o_busy          (o_busy),
    .o_frame_done    (o_frame_done)
  );

  always #5 i_clk = ~i_clk;

  logic [7:0] seg_tab [0:9] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  // Expected shift word for digit k, straight from the display rules
  function automatic logic [15:0] model_word(input logic [23:0] bcd, input logic c,
                                             input logic b, input int k);
    logic [3:0] nib;
    logic [7:0] seg;
    nib = 4'((bcd >> (4 * (5 - k))) & 24'hF);
    seg = (nib > 4'd9) ? 8'h40 : seg_tab[nib];
    if (k == 0 && nib == 4'd0) seg = 8'h00;
    if (c && (k == 1 || k == 3)) seg = seg | 8'h80;
    if (b) seg = 8'h00;
    return {seg, 8'(1 << k)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Downstream shift register: captures each started word, acks and finishes after random delays
  int          cyc = 0;
  int          starts = 0;
  int          dones = 0;
  logic [15:0] words[$];
  int          start_cyc[$];
  int          done_cyc[$];
  int          phase = 0;
  int          ack_dly = 0;
  int          busy_len = 0;
  bit          sr_enable = 1'b1;
  bit          sr_long = 1'b0;

  always @(negedge i_clk) begin
    cyc++;
    if (!i_reset_n) begin
      phase = 0;
      i_busy = 1'b0;
    end else begin
      if (o_start_stb) begin
        words.push_back(o_parallel_data);
        start_cyc.push_back(cyc);
        starts++;
        if (sr_enable) begin
          ack_dly = $urandom_range(0, 3);
          busy_len = sr_long ? 20 : $urandom_range(1, 5);
          phase = 1;
        end
      end else if (phase == 1) begin
        if (ack_dly == 0) begin i_busy = 1'b1; phase = 2; end
        else ack_dly--;
      end else if (phase == 2) begin
        if (busy_len == 0) begin i_busy = 1'b0; phase = 0; end
        else busy_len--;
      end
      if (o_frame_done) begin
        dones++;
        done_cyc.push_back(cyc);
      end
    end
  end

  task automatic pulse_strobe();
    i_refresh_stb = 1'b1;
    @(negedge i_clk);
    i_refresh_stb = 1'b0;
  endtask

  task automatic wait_dones(input string tag, input int target);
    for (int t = 0; t < 3000 && dones < target; t++) @(negedge i_clk);
    check({tag, "_timeout"}, 32'(dones >= target), 32'd1);
  endtask

  task automatic check_words(input string tag, input int base, input logic [23:0] bcd,
                             input logic c, input logic b);
    logic [15:0] w;
    for (int k = 0; k < ND; k++) begin
      w = (base + k < words.size()) ? words[base + k] : 16'hxxxx;
      check($sformatf("%s_w%0d", tag, k), {16'h0, w}, {16'h0, model_word(bcd, c, b, k)});
    end
  endtask

  task automatic run_frame(input string tag, input logic [23:0] bcd, input logic c,
                           input logic b, output int base);
    int d0;
    base = words.size();
    d0 = dones;
    i_bcd_time = bcd;
    i_colon = c;
    i_blank = b;
    pulse_strobe();
    i_bcd_time = 24'($urandom);
    i_colon = ~c;
    i_blank = ~b;
    wait_dones(tag, d0 + 1);
    repeat (3) @(negedge i_clk);
    check({tag, "_dones"}, 32'(dones - d0), 32'd1);
    check({tag, "_nwords"}, 32'(words.size() - base), 32'(ND));
    check_words(tag, base, bcd, c, b);
  endtask

  initial begin
    int base, b2, s0, d0, sbase;
    logic [23:0] rb;
    logic rc, rbl;

    repeat (3) @(negedge i_clk);
    check("rst_data", {16'h0, o_parallel_data}, 32'h0);
    check("rst_start", 32'(o_start_stb), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_frame_done), 32'd0);
    i_reset_n = 1'b1;
    repeat (10) @(negedge i_clk);
    check("post_rst_no_start", 32'(starts), 32'd0);
    check("post_rst_idle", 32'(o_busy), 32'd0);

    run_frame("basic", 24'h123456, 1'b0, 1'b0, base);
    check("basic_w0_const", {16'h0, words[base]}, 32'h0601);
    check("basic_w5_const", {16'h0, words[base + 5]}, 32'h7D20);

    run_frame("colon", 24'h094500, 1'b1, 1'b0, base);
    check("colon_w0_const", {16'h0, words[base]}, 32'h0001);
    check("colon_w1_const", {16'h0, words[base + 1]}, 32'hEF02);
    check("colon_w3_dp", 32'(words[base + 3][15]), 32'd1);

    run_frame("blank", 24'h235959, 1'b1, 1'b1, base);
    run_frame("dash", 24'hA00000, 1'b0, 1'b0, base);
    check("dash_w0_const", {16'h0, words[base]}, 32'h4001);

    for (int r = 0; r < 6; r++) begin
      rb = 24'($urandom);
      if (r % 2 == 0)
        for (int n = 0; n < 6; n++) rb[4*n +: 4] = 4'($urandom_range(0, 9));
      rc = 1'($urandom);
      rbl = (r == 5) ? 1'b1 : 1'b0;
      run_frame($sformatf("rand%0d", r), rb, rc, rbl, base);
    end

    base = words.size();
    s0 = starts;
    d0 = dones;
    i_bcd_time = 24'h081529;
    i_colon = 1'b1;
    i_blank = 1'b0;
    pulse_strobe();
    repeat (5) @(negedge i_clk);
    pulse_strobe();
    repeat (7) @(negedge i_clk);
    pulse_strobe();
    repeat (7) @(negedge i_clk);
    pulse_strobe();
    wait_dones("pend", d0 + 2);
    repeat (60) @(negedge i_clk);
    check("pend_dones", 32'(dones - d0), 32'd2);
    check("pend_starts", 32'(starts - s0), 32'(2 * ND));
    if (done_cyc.size() > d0 && start_cyc.size() > s0 + ND)
      check("pend_restart_cycle", 32'(start_cyc[s0 + ND]), 32'(done_cyc[d0] + 3));
    else
      check("pend_restart_cycle", 32'hFFFF_FFFF, 32'(ND));
    check_words("pend_f1", base, 24'h081529, 1'b1, 1'b0);
    check_words("pend_f2", base + ND, 24'h081529, 1'b1, 1'b0);

    sr_enable = 1'b0;
    s0 = starts;
    d0 = dones;
    i_bcd_time = 24'h111111;
    pulse_strobe();
    for (int t = 0; t < 100 && starts == s0; t++) @(negedge i_clk);
    repeat (50) @(negedge i_clk);
    check("noack_starts", 32'(starts - s0), 32'd1);
    check("noack_busy", 32'(o_busy), 32'd1);
    check("noack_dones", 32'(dones - d0), 32'd0);
    i_reset_n = 1'b0;
    @(negedge i_clk);
    i_reset_n = 1'b1;
    sr_enable = 1'b1;
    repeat (2) @(negedge i_clk);

    sr_long = 1'b1;
    sbase = starts;
    i_bcd_time = 24'h204837;
    i_colon = 1'b1;
    i_blank = 1'b0;
    pulse_strobe();
    for (int t = 0; t < 500 && !(starts >= sbase + 3 && i_busy); t++) @(negedge i_clk);
    check("rstmid_reached", 32'(starts - sbase), 32'd3);
    repeat (2) @(negedge i_clk);
    check("rstmid_pre_word", {16'h0, o_parallel_data}, {16'h0, model_word(24'h204837, 1'b1, 1'b0, 2)});
    check("rstmid_pre_busy", 32'(o_busy), 32'd1);
    #2 i_reset_n = 1'b0;
    #1;
    check("rstmid_data", {16'h0, o_parallel_data}, 32'h0);
    check("rstmid_busy", 32'(o_busy), 32'd0);
    check("rstmid_start", 32'(o_start_stb), 32'd0);
    check("rstmid_done", 32'(o_frame_done), 32'd0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    sr_long = 1'b0;
    b2 = starts;
    repeat (30) @(negedge i_clk);
    check("rstmid_no_restart", 32'(starts - b2), 32'd0);
    check("rstmid_idle", 32'(o_busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
